multi_lockin: RTL and testbench

MULTI_LOCKIN -- requirements
Module: multi_lockin

---
 rtl/multi_lockin.sv | 210 +++++++++++++++++++++
 tb/tb_multi_lockin.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lockin.sv
// ---------------------------------------------------------------------------
// multi_lockin
//
// Multi-channel lock-in amplifier. Each accepted input sample is multiplied
// by an in-phase (sin) and a quadrature (cos) reference, one channel per
// clock, through a single shared pair of multipliers. The scaled products
// are accumulated over DECIM samples, then averaged, saturated and presented
// on x_o / y_o together with a one-cycle done_o pulse.
//
// Ports
//   clk_i      : clock, all logic on the rising edge
//   reset_i    : synchronous, active-high reset
//   tick_i     : one-cycle pulse, a new sample is present on data_i/ref_*_i
//   data_i     : NUM_CH signed samples, channel k at [k*NUM_BITS +: NUM_BITS]
//   ref_sin_i  : signed in-phase reference
//   ref_cos_i  : signed quadrature reference
//   x_o        : signed in-phase results, packed like data_i
//   y_o        : signed quadrature results, packed like data_i
//   done_o     : one-cycle pulse, x_o/y_o carry fresh results
//   busy_o     : high while a sample is being processed
//   overrun_o  : sticky, a tick arrived while busy and was dropped
//   count_o    : number of done_o pulses, wraps at 2^32
// ---------------------------------------------------------------------------
module multi_lockin #(
    parameter int NUM_CH   = 4,
    parameter int NUM_BITS = 24,
    parameter int DECIM    = 64
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         tick_i,
    input  logic [NUM_CH*NUM_BITS-1:0]   data_i,
    input  logic [NUM_BITS-1:0]          ref_sin_i,
    input  logic [NUM_BITS-1:0]          ref_cos_i,
    output logic [NUM_CH*NUM_BITS-1:0]   x_o,
    output logic [NUM_CH*NUM_BITS-1:0]   y_o,
    output logic                         done_o,
    output logic                         busy_o,
    output logic                         overrun_o,
    output logic [31:0]                  count_o
);

    localparam int ACC_SHIFT = $clog2(DECIM);
    localparam int ACC_W     = NUM_BITS + ACC_SHIFT + 1;
    localparam int PROD_W    = 2 * NUM_BITS;
    localparam int TERM_W    = NUM_BITS + 1;
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SC_W      = (ACC_SHIFT > 0) ? ACC_SHIFT : 1;

    localparam logic [CH_W-1:0] LAST_CH     = CH_W'(NUM_CH - 1);
    localparam logic [SC_W-1:0] LAST_SAMPLE = SC_W'(DECIM - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(NUM_BITS-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        FIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [CH_W-1:0]               ch;
    logic [SC_W-1:0]               samp;
    logic [NUM_CH*NUM_BITS-1:0]    data_r;
    logic signed [NUM_BITS-1:0]    sin_r;
    logic signed [NUM_BITS-1:0]    cos_r;
    logic signed [ACC_W-1:0]       acc_x [NUM_CH];
    logic signed [ACC_W-1:0]       acc_y [NUM_CH];

    logic signed [NUM_BITS-1:0]    cur_d;
    logic signed [PROD_W-1:0]      prod_x;
    logic signed [PROD_W-1:0]      prod_y;
    logic signed [TERM_W-1:0]      px;
    logic signed [TERM_W-1:0]      py;
    logic signed [ACC_W-1:0]       upd_x [NUM_CH];
    logic signed [ACC_W-1:0]       upd_y [NUM_CH];

    logic accept;
    logic drop;
    logic last_mac;
    logic dump;

    // Average (arithmetic shift = floor) and clamp to the output range.
    function automatic logic signed [NUM_BITS-1:0] saturate(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> ACC_SHIFT;
        if (s > SAT_MAX) begin
            return SAT_MAX[NUM_BITS-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[NUM_BITS-1:0];
        end else begin
            return s[NUM_BITS-1:0];
        end
    endfunction

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick_i) state_next = MAC;
            MAC:     if (ch == LAST_CH) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM decodes. The dump is decided on the last MAC cycle so that the
    // registered results and done_o appear together during FIN.
    always_comb begin
        busy_o   = (state != IDLE);
        accept   = (state == IDLE) && tick_i;
        drop     = (state != IDLE) && tick_i;
        last_mac = (state == MAC) && (ch == LAST_CH);
        dump     = last_mac && (samp == LAST_SAMPLE);
    end

    // Select the channel under processing from the captured sample.
    always_comb begin
        cur_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch == CH_W'(k)) begin
                cur_d = data_r[k*NUM_BITS +: NUM_BITS];
            end
        end
    end

    // Shared multiplier pair; keeping NUM_BITS+1 bits after the floor shift
    // leaves room for the full-scale negative times full-scale negative case.
    assign prod_x = cur_d * sin_r;
    assign prod_y = cur_d * cos_r;
    assign px     = TERM_W'(prod_x >>> (NUM_BITS - 1));
    assign py     = TERM_W'(prod_y >>> (NUM_BITS - 1));

    // Accumulator values including the product of the current MAC cycle.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            upd_x[k] = acc_x[k];
            upd_y[k] = acc_y[k];
            if ((state == MAC) && (ch == CH_W'(k))) begin
                upd_x[k] = acc_x[k] + ACC_W'(px);
                upd_y[k] = acc_y[k] + ACC_W'(py);
            end
        end
    end

    // Datapath: capture, channel stepping, accumulation, dump and status.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ch        <= '0;
            samp      <= '0;
            data_r    <= '0;
            sin_r     <= '0;
            cos_r     <= '0;
            x_o       <= '0;
            y_o       <= '0;
            done_o    <= 1'b0;
            overrun_o <= 1'b0;
            count_o   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_x[k] <= '0;
                acc_y[k] <= '0;
            end
        end else begin
            done_o <= dump;

            if (drop) begin
                overrun_o <= 1'b1;
            end

            if (accept) begin
                data_r <= data_i;
                sin_r  <= ref_sin_i;
                cos_r  <= ref_cos_i;
                ch     <= '0;
            end else if ((state == MAC) && (ch != LAST_CH)) begin
                ch <= ch + 1'b1;
            end

            for (int k = 0; k < NUM_CH; k++) begin
                acc_x[k] <= dump ? '0 : upd_x[k];
                acc_y[k] <= dump ? '0 : upd_y[k];
            end

            if (dump) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    x_o[k*NUM_BITS +: NUM_BITS] <= saturate(upd_x[k]);
                    y_o[k*NUM_BITS +: NUM_BITS] <= saturate(upd_y[k]);
                end
                count_o <= count_o + 32'd1;
            end

            if (state == FIN) begin
                samp <= (samp == LAST_SAMPLE) ? '0 : samp + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_lockin.sv
// ---------------------------------------------------------------------------
// tb_multi_lockin
//
// Self-checking bench for multi_lockin (NUM_CH=4, NUM_BITS=24, DECIM=4).
// A behavioural model keeps per-channel running sums as plain integers and
// produces the expected averaged, clamped outputs; every cycle of every
// sample window is compared against it. Fixed vectors with hand-derived
// results, an overrun sequence, a mid-sample reset and a randomized phase
// complete the run.
// ---------------------------------------------------------------------------
module tb_multi_lockin;

    localparam int NUM_CH   = 4;
    localparam int NUM_BITS = 24;
    localparam int DECIM    = 4;
    localparam int W        = NUM_CH * NUM_BITS;
    localparam longint FS_MAX = 8388607;
    localparam longint FS_MIN = -8388608;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           tick_i;
    logic [W-1:0]   data_i;
    logic [23:0]    ref_sin_i;
    logic [23:0]    ref_cos_i;
    logic [W-1:0]   x_o;
    logic [W-1:0]   y_o;
    logic           done_o;
    logic           busy_o;
    logic           overrun_o;
    logic [31:0]    count_o;

    multi_lockin #(
        .NUM_CH   (NUM_CH),
        .NUM_BITS (NUM_BITS),
        .DECIM    (DECIM)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .tick_i    (tick_i),
        .data_i    (data_i),
        .ref_sin_i (ref_sin_i),
        .ref_cos_i (ref_cos_i),
        .x_o       (x_o),
        .y_o       (y_o),
        .done_o    (done_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o),
        .count_o   (count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    longint sumX [NUM_CH];
    longint sumY [NUM_CH];
    longint pendX [NUM_CH];
    longint pendY [NUM_CH];
    longint shownX [NUM_CH];
    longint shownY [NUM_CH];
    int     modelSamples;
    longint shownCount;
    longint modelOverrun;

    typedef struct {
        string        name;
        logic [W-1:0] data;
        logic [23:0]  s;
        logic [23:0]  c;
        logic [W-1:0] ex;
        logic [W-1:0] ey;
        longint       cnt;
    } vec_t;

    vec_t vectors [3];

    function automatic longint toS(input logic [23:0] v);
        logic signed [23:0] t;
        t = v;
        return longint'(t);
    endfunction

    function automatic longint lane(input logic [W-1:0] v, input int k);
        logic [23:0] t;
        t = v[k*NUM_BITS +: NUM_BITS];
        return toS(t);
    endfunction

    function automatic logic [W-1:0] pack4(input longint a0, input longint a1,
                                           input longint a2, input longint a3);
        logic [W-1:0] v;
        longint t;
        t = a0; v[0*NUM_BITS +: NUM_BITS] = t[23:0];
        t = a1; v[1*NUM_BITS +: NUM_BITS] = t[23:0];
        t = a2; v[2*NUM_BITS +: NUM_BITS] = t[23:0];
        t = a3; v[3*NUM_BITS +: NUM_BITS] = t[23:0];
        return v;
    endfunction

    // Mathematical floor of a/b for b > 0.
    function automatic longint floorDiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint clampFs(input longint v);
        if (v > FS_MAX) return FS_MAX;
        if (v < FS_MIN) return FS_MIN;
        return v;
    endfunction

    function automatic logic [23:0] randSample();
        logic [31:0] r;
        r = $urandom();
        case (r[31:29])
            3'd0:    return 24'h800000;
            3'd1:    return 24'h7fffff;
            default: return r[23:0];
        endcase
    endfunction

    function automatic logic [W-1:0] randData();
        logic [W-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[k*NUM_BITS +: NUM_BITS] = randSample();
        return v;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < NUM_CH; k++) begin
            sumX[k] = 0; sumY[k] = 0; shownX[k] = 0; shownY[k] = 0;
            pendX[k] = 0; pendY[k] = 0;
        end
        modelSamples = 0;
        shownCount   = 0;
        modelOverrun = 0;
    endtask

    // Accept one sample into the model; returns 1 when it completes a window.
    function automatic bit modelTick(input logic [W-1:0] d, input logic [23:0] s,
                                     input logic [23:0] c);
        for (int k = 0; k < NUM_CH; k++) begin
            sumX[k] += floorDiv(lane(d, k) * toS(s), 64'sd8388608);
            sumY[k] += floorDiv(lane(d, k) * toS(c), 64'sd8388608);
        end
        modelSamples++;
        if (modelSamples == DECIM) begin
            for (int k = 0; k < NUM_CH; k++) begin
                pendX[k] = clampFs(floorDiv(sumX[k], DECIM));
                pendY[k] = clampFs(floorDiv(sumY[k], DECIM));
                sumX[k] = 0;
                sumY[k] = 0;
            end
            modelSamples = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkCycle(input bit expDone, input bit expBusy);
        checkOutput("done", longint'(done_o), longint'(expDone));
        checkOutput("busy", longint'(busy_o), longint'(expBusy));
        checkOutput("overrun", longint'(overrun_o), modelOverrun);
        checkOutput("count", longint'(count_o), shownCount);
        for (int k = 0; k < NUM_CH; k++) begin
            checkOutput($sformatf("x_ch%0d", k), lane(x_o, k), shownX[k]);
            checkOutput($sformatf("y_ch%0d", k), lane(y_o, k), shownY[k]);
        end
    endtask

    // Issue one tick at the current falling edge and check every cycle of the
    // window. dropAt > 0 injects a second tick at that cycle of the window.
    task automatic applyStimulus(input logic [W-1:0] d, input logic [23:0] s,
                                 input logic [23:0] c, input int gap, input int dropAt);
        bit willDump;
        tick_i    = 1'b1;
        data_i    = d;
        ref_sin_i = s;
        ref_cos_i = c;
        @(negedge clk_i);
        tick_i   = 1'b0;
        willDump = modelTick(d, s, c);
        for (int cyc = 1; cyc < gap; cyc++) begin
            if (willDump && cyc == NUM_CH + 1) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    shownX[k] = pendX[k];
                    shownY[k] = pendY[k];
                end
                shownCount++;
            end
            checkCycle(willDump && (cyc == NUM_CH + 1), cyc <= NUM_CH + 1);
            if (cyc == dropAt) begin
                tick_i    = 1'b1;
                data_i    = randData();
                ref_sin_i = randSample();
                ref_cos_i = randSample();
                @(negedge clk_i);
                tick_i       = 1'b0;
                modelOverrun = 1;
            end else begin
                @(negedge clk_i);
            end
        end
    endtask

    initial begin
        modelReset();

        vectors[0].name = "basic_avg";
        vectors[0].data = pack4(4194304, 0, 0, 0);
        vectors[0].s    = 24'd8388607;
        vectors[0].c    = 24'd0;
        vectors[0].ex   = pack4(4194303, 0, 0, 0);
        vectors[0].ey   = pack4(0, 0, 0, 0);
        vectors[0].cnt  = 1;

        vectors[1].name = "order_sign";
        vectors[1].data = pack4(100, -100, 4194304, -1);
        vectors[1].s    = 24'd8388607;
        vectors[1].c    = 24'h800000;
        vectors[1].ex   = pack4(99, -100, 4194303, -1);
        vectors[1].ey   = pack4(-100, 100, -4194304, 1);
        vectors[1].cnt  = 2;

        vectors[2].name = "saturate";
        vectors[2].data = pack4(-8388608, -8388608, -8388608, -8388608);
        vectors[2].s    = 24'h800000;
        vectors[2].c    = 24'h800000;
        vectors[2].ex   = pack4(8388607, 8388607, 8388607, 8388607);
        vectors[2].ey   = pack4(8388607, 8388607, 8388607, 8388607);
        vectors[2].cnt  = 3;

        // Reset held two cycles with tick asserted.
        reset_i   = 1'b1;
        tick_i    = 1'b1;
        data_i    = randData();
        ref_sin_i = 24'd8388607;
        ref_cos_i = 24'd8388607;
        @(negedge clk_i);
        @(negedge clk_i);
        checkCycle(1'b0, 1'b0);
        reset_i = 1'b0;
        tick_i  = 1'b0;
        @(negedge clk_i);
        checkCycle(1'b0, 1'b0);

        // Fixed vectors with hand-derived results.
        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < DECIM; t++) begin
                applyStimulus(vectors[i].data, vectors[i].s, vectors[i].c, 8, 0);
            end
            for (int k = 0; k < NUM_CH; k++) begin
                checkOutput($sformatf("%s_x%0d", vectors[i].name, k), lane(x_o, k), lane(vectors[i].ex, k));
                checkOutput($sformatf("%s_y%0d", vectors[i].name, k), lane(y_o, k), lane(vectors[i].ey, k));
            end
            checkOutput($sformatf("%s_count", vectors[i].name), longint'(count_o), vectors[i].cnt);
        end

        // Overrun: second tick three cycles after the first is dropped.
        applyStimulus(pack4(4194304, 0, 0, 0), 24'd8388607, 24'd0, 8, 3);
        for (int t = 1; t < DECIM; t++) begin
            applyStimulus(pack4(4194304, 0, 0, 0), 24'd8388607, 24'd0, 8, 0);
        end
        checkOutput("overrun_sticky", longint'(overrun_o), 1);
        checkOutput("overrun_count", longint'(count_o), 4);
        checkOutput("overrun_x0", lane(x_o, 0), 4194303);

        // Reset during the second MAC cycle.
        tick_i    = 1'b1;
        data_i    = pack4(4194304, 0, 0, 0);
        ref_sin_i = 24'd8388607;
        ref_cos_i = 24'd0;
        @(negedge clk_i);
        tick_i = 1'b0;
        checkOutput("mid_busy1", longint'(busy_o), 1);
        @(negedge clk_i);
        checkOutput("mid_busy2", longint'(busy_o), 1);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        modelReset();
        checkCycle(1'b0, 1'b0);
        @(negedge clk_i);
        for (int t = 0; t < DECIM; t++) begin
            applyStimulus(pack4(4194304, 0, 0, 0), 24'd8388607, 24'd0, 8, 0);
        end
        checkOutput("mid_reset_x0", lane(x_o, 0), 4194303);
        checkOutput("mid_reset_y0", lane(y_o, 0), 0);
        checkOutput("mid_reset_count", longint'(count_o), 1);
        checkOutput("mid_reset_overrun", longint'(overrun_o), 0);

        // Randomized samples, spacing and occasional overruns.
        for (int n = 0; n < 48; n++) begin
            int gap;
            int dropAt;
            gap    = NUM_CH + 2 + int'($urandom_range(0, 3));
            dropAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, NUM_CH + 1)) : 0;
            applyStimulus(randData(), randSample(), randSample(), gap, dropAt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
